// File: rtl/board_row_server.sv
// Tetris board store (10x20 cells) that serves whole rows to the display through a shadow buffer.
// Optional BOARD_CLEAR_EN adds a sweeping board clear (clear_req / clear_busy).
module board_row_server #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int CELL_W = 16
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         LD_Row,
    input  logic [7:0]                   rowNum,
    output logic [COLS-1:0][CELL_W-1:0]  Row,
    output logic                         rowReady,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_col,
    input  logic [4:0]                   wr_row,
    input  logic [CELL_W-1:0]            wr_data
`ifdef BOARD_CLEAR_EN
    ,
    input  logic                         clear_req,
    output logic                         clear_busy
`endif
);

    // state  | meaning
    // IDLE   | waiting for a rising edge on LD_Row
    // FETCH  | issuing one store read per cycle, col 0..9
    // DRAIN  | last read in flight, capture col 9
    // COMMIT | copy shadow into Row, raise rowReady
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

    localparam logic [7:0] COLS8    = 8'(COLS);
    localparam logic [3:0] COLS4    = 4'(COLS);
    localparam logic [4:0] ROWS5    = 5'(ROWS);
    localparam logic [7:0] ROWS8    = 8'(ROWS);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    logic [CELL_W-1:0]            mem [ROWS*COLS];
    logic [CELL_W-1:0]            rd_q;
    logic [COLS-1:0][CELL_W-1:0]  shadow;
    state_t                       state;
    logic [7:0]                   req_row;
    logic [3:0]                   col;
    logic [3:0]                   rd_col;
    logic                         rd_valid;
    logic                         stall_first;
    logic                         LD_Row_q;

    logic                         clearing;
    logic                         req_edge;
    logic                         req_go;
    logic [7:0]                   req_row_in;
    logic                         wr_ok;
    logic                         row_ok;
    logic                         fetch_run;
    logic                         rd_issue;
    logic                         col_adv;
    logic [7:0]                   rd_addr;
    logic [7:0]                   wr_addr;

    assign req_edge = LD_Row & ~LD_Row_q;

`ifdef BOARD_CLEAR_EN
    logic [7:0] clr_addr;
    logic       req_pend;
    logic [7:0] pend_row;

    assign clearing   = clear_busy;
    // A request seen during a clear is held and served once the sweep ends.
    assign req_go     = !clearing && (req_edge || req_pend);
    assign req_row_in = req_edge ? rowNum : pend_row;

    always_ff @(posedge Clk) begin
        if (reset) begin
            clear_busy <= 1'b0;
            clr_addr   <= '0;
            req_pend   <= 1'b0;
            pend_row   <= '0;
        end else begin
            if (clear_busy) begin
                if (clr_addr == 8'(ROWS*COLS - 1))
                    clear_busy <= 1'b0;
                clr_addr <= clr_addr + 8'd1;
            end else if (clear_req) begin
                clear_busy <= 1'b1;
                clr_addr   <= '0;
            end
            if (clearing && req_edge) begin
                req_pend <= 1'b1;
                pend_row <= rowNum;
            end else if (req_go) begin
                req_pend <= 1'b0;
            end
        end
    end
`else
    assign clearing   = 1'b0;
    assign req_go     = req_edge;
    assign req_row_in = rowNum;
`endif

    assign wr_ok   = wr_en && (wr_col < COLS4) && (wr_row < ROWS5) && !clearing;
    assign row_ok  = req_row < ROWS8;
    assign rd_addr = req_row * COLS8 + {4'b0, col};
    assign wr_addr = {3'b0, wr_row} * COLS8 + {4'b0, wr_col};

    // Out-of-range rows still walk the columns so timing matches, but never touch the port.
    assign fetch_run = (state == FETCH) && !clearing && !req_go && !stall_first;
    assign rd_issue  = fetch_run && row_ok && !wr_ok;
    assign col_adv   = fetch_run && !(row_ok && wr_ok);

    always_ff @(posedge Clk) begin
        if (reset) begin
            mem  <= '{default: '0};
            rd_q <= '0;
        end else begin
`ifdef BOARD_CLEAR_EN
            if (clear_busy)
                mem[clr_addr] <= '0;
`endif
            if (wr_ok)
                mem[wr_addr] <= wr_data;
            if (rd_issue)
                rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            req_row     <= '0;
            col         <= '0;
            rd_col      <= '0;
            rd_valid    <= 1'b0;
            stall_first <= 1'b0;
            shadow      <= '0;
            Row         <= '0;
            rowReady    <= 1'b0;
            LD_Row_q    <= 1'b0;
        end else begin
            LD_Row_q <= LD_Row;
            rd_valid <= rd_issue;
            rd_col   <= col;
            if (rd_valid)
                shadow[rd_col] <= rd_q;

            if (req_go) begin
                // New request (or abort of one in progress): restart from col 0.
                state       <= FETCH;
                req_row     <= req_row_in;
                col         <= '0;
                rd_valid    <= 1'b0;
                shadow      <= '0;
                stall_first <= wr_ok;
                rowReady    <= 1'b0;
            end else if (!clearing) begin
                case (state)
                    IDLE: state <= IDLE;
                    FETCH: begin
                        if (stall_first) begin
                            stall_first <= 1'b0;
                        end else if (col_adv) begin
                            col <= col + 4'd1;
                            if (col == LAST_COL)
                                state <= DRAIN;
                        end
                    end
                    DRAIN: state <= COMMIT;
                    COMMIT: begin
                        Row      <= shadow;
                        rowReady <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_row_server.sv
// Directed bench for board_row_server: latency, hold, stall, out-of-range, abort, reset.
// Exercises the BOARD_CLEAR_EN sweep when that macro is defined.
module tb_board_row_server;

    logic              Clk;
    logic              reset;
    logic              LD_Row;
    logic [7:0]        rowNum;
    logic [9:0][15:0]  Row;
    logic              rowReady;
    logic              wr_en;
    logic [3:0]        wr_col;
    logic [4:0]        wr_row;
    logic [15:0]       wr_data;
`ifdef BOARD_CLEAR_EN
    logic              clear_req;
    logic              clear_busy;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0][15:0] exp_row;

    board_row_server dut (
        .Clk      (Clk),
        .reset    (reset),
        .LD_Row   (LD_Row),
        .rowNum   (rowNum),
        .Row      (Row),
        .rowReady (rowReady),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_row   (wr_row),
        .wr_data  (wr_data)
`ifdef BOARD_CLEAR_EN
        ,
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [3:0] c, input logic [4:0] r, input logic [15:0] d);
        wr_en = 1'b1; wr_col = c; wr_row = r; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    // Leaves the bench just after the accepting edge.
    task automatic start_req(input logic [7:0] r);
        LD_Row = 1'b0;
        tick;
        rowNum = r;
        LD_Row = 1'b1;
        tick;
    endtask

    // Called just after the accepting edge; commit expected exactly 'edges' edges later.
    task automatic expect_commit(input string tag, input int edges);
        for (int i = 1; i < edges; i++) tick;
        chk({tag, "_early"}, {159'b0, rowReady}, 160'd0);
        tick;
        chk({tag, "_ready"}, {159'b0, rowReady}, 160'd1);
    endtask

    initial begin
        int drops;
        reset = 1'b1; LD_Row = 1'b0; rowNum = '0;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
`ifdef BOARD_CLEAR_EN
        clear_req = 1'b0;
`endif
        tick; tick;
        reset = 1'b0;
        chk("reset_ready", {159'b0, rowReady}, 160'd0);
        chk("reset_row", Row, 160'd0);

        // Basic fetch, 12-edge latency
        write_cell(4'd3, 5'd5, 16'h0F00);
        write_cell(4'd0, 5'd6, 16'h0123);
        start_req(8'd5);
        chk("accept_ready_low", {159'b0, rowReady}, 160'd0);
        expect_commit("row5", 12);
        exp_row = '0; exp_row[3] = 16'h0F00;
        chk("row5_data", Row, exp_row);

        // LD_Row held: 40 cycles total high, no re-trigger
        drops = 0;
        for (int i = 0; i < 28; i++) begin
            tick;
            if (rowReady !== 1'b1) drops++;
        end
        chk("hold_no_drop", 160'(drops), 160'd0);
        chk("hold_row", Row, exp_row);

        // Write mid-fetch to a not-yet-read column costs one stall edge
        write_cell(4'd0, 5'd2, 16'h0111);
        write_cell(4'd9, 5'd2, 16'h0999);
        start_req(8'd2);
        tick; tick; tick;
        wr_en = 1'b1; wr_col = 4'd7; wr_row = 5'd2; wr_data = 16'h0777;
        tick;
        wr_en = 1'b0;
        expect_commit("stall", 9);
        exp_row = '0; exp_row[0] = 16'h0111; exp_row[7] = 16'h0777; exp_row[9] = 16'h0999;
        chk("stall_data", Row, exp_row);

        // Request edge together with a write: first read stalls
        LD_Row = 1'b0;
        tick;
        rowNum = 8'd5; LD_Row = 1'b1;
        wr_en = 1'b1; wr_col = 4'd1; wr_row = 5'd5; wr_data = 16'h0A0A;
        tick;
        wr_en = 1'b0;
        expect_commit("simul", 13);
        exp_row = '0; exp_row[1] = 16'h0A0A; exp_row[3] = 16'h0F00;
        chk("simul_data", Row, exp_row);

        // Out-of-range write is ignored; last row (address 199) is reachable
        write_cell(4'd10, 5'd19, 16'h0BAD);
        write_cell(4'd9, 5'd19, 16'h0F0F);
        start_req(8'd19);
        expect_commit("row19", 12);
        exp_row = '0; exp_row[9] = 16'h0F0F;
        chk("row19_data", Row, exp_row);

        // Out-of-range row commits zeros with normal timing
        start_req(8'd25);
        expect_commit("oor", 12);
        chk("oor_data", Row, 160'd0);

        // Abort: row 1 request overtaken by row 7 at edge 6
        write_cell(4'd4, 5'd1, 16'h0414);
        write_cell(4'd2, 5'd7, 16'h0727);
        start_req(8'd1);
        LD_Row = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rowNum = 8'd7; LD_Row = 1'b1;
        tick;
        drops = 0;
        for (int i = 1; i < 12; i++) begin
            tick;
            if (rowReady !== 1'b0) drops++;
        end
        chk("abort_no_commit", 160'(drops), 160'd0);
        chk("abort_row_kept", Row, 160'd0);
        tick;
        chk("abort_ready", {159'b0, rowReady}, 160'd1);
        exp_row = '0; exp_row[2] = 16'h0727;
        chk("abort_data", Row, exp_row);

        // Reset mid-fetch: no commit, store cleared
        start_req(8'd5);
        tick; tick; tick;
        reset = 1'b1; LD_Row = 1'b0;
        tick;
        reset = 1'b0;
        chk("rst_mid_row", Row, 160'd0);
        chk("rst_mid_ready", {159'b0, rowReady}, 160'd0);
        drops = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (rowReady !== 1'b0) drops++;
        end
        chk("rst_mid_no_commit", 160'(drops), 160'd0);
        start_req(8'd7);
        expect_commit("rst_store", 12);
        chk("rst_store_data", Row, 160'd0);

`ifdef BOARD_CLEAR_EN
        begin
            int busy_cnt;
            int waited;
            for (int c = 0; c < 10; c++) write_cell(4'(c), 5'd0, 16'h0FFF);
            LD_Row = 1'b0;
            clear_req = 1'b1;
            tick;
            clear_req = 1'b0;
            rowNum = 8'd0; LD_Row = 1'b1;
            busy_cnt = (clear_busy === 1'b1) ? 1 : 0;
            for (int i = 0; i < 300 && clear_busy === 1'b1; i++) begin
                tick;
                if (clear_busy === 1'b1) busy_cnt++;
            end
            chk("clear_busy_len", 160'(busy_cnt), 160'd200);
            waited = 0;
            while (rowReady !== 1'b1 && waited < 40) begin
                tick;
                waited++;
            end
            chk("clear_fetch_done", {159'b0, rowReady}, 160'd1);
            chk("clear_row_zero", Row, 160'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_row_server.md
Name: board_row_server

Overview:
- Owns the 10x20 Tetris board store: 200 cells of 16 bits each, with 12-bit RGB in [11:0].
- Serves whole rows to the display colour mapper over the LD_Row/rowNum request and Row/rowReady response interface.
- Game logic writes single cells through a write port. Row fetches read the store one cell per cycle through a single synchronous read port.
- Fetched cells go into a shadow buffer, which is committed atomically to Row so the display never sees a partially updated row.

Parameters:
- COLS, 10, cells per board row.
- ROWS, 20, board rows.
- CELL_W, 16, bits per cell.

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- LD_Row  in  1  row load request; level signal, may be held for many cycles.
- rowNum  in  8  requested board row.
- Row  out  COLS x CELL_W  committed row data, column 0 first.
- rowReady  out  1  Row is valid for the last accepted request.
- wr_en  in  1  cell write strobe.
- wr_col  in  4  write column.
- wr_row  in  5  write row.
- wr_data  in  16  write data.

Behaviour:
- Reset values:
  - All 200 cells = 0.
  - Row = all zeros; rowReady = 0.
  - State IDLE; shadow buffer = 0; LD_Row_q = 0.
- Request detection:
  - A request is a rising edge of LD_Row, with LD_Row_q registered each cycle.
  - rowNum is sampled on the accepting edge.
  - Holding LD_Row high does not re-trigger a fetch.
- FSM states:
  - IDLE -> FETCH on an accepted request. Latch req_row and set col = 0. rowReady drops to 0 on the same edge.
  - FETCH: each cycle without a stall, issue a read of address req_row*COLS + col and increment col. After col 9 is issued, go to DRAIN.
  - DRAIN: capture the data for col 9, then go to COMMIT.
  - COMMIT: Row <= shadow buffer, rowReady <= 1, go to IDLE.
- Read data:
  - Read latency is 1 cycle.
  - The data for col k is captured into shadow[k] on the edge after its read is issued.
- Latency:
  - Row/rowReady update exactly 12 edges after the accepting edge when no write occurs.
  - Each stall cycle adds one edge.
- Out-of-range rows:
  - If req_row >= ROWS, no store reads are issued and shadow is forced to 0.
  - The same 12-edge timing is kept, and the row commits as all zeros.
- Abort:
  - A new rising edge of LD_Row during FETCH or DRAIN aborts the current fetch and restarts FETCH with the new rowNum, col = 0.
  - The previous shadow contents are discarded. Row keeps its last committed value and rowReady stays 0.
- Write/read arbitration (single port):
  - A wr_en with wr_col < COLS and wr_row < ROWS takes the port that cycle, and any read due that cycle stalls.
  - Writes with out-of-range coordinates are ignored and cause no stall.
  - A write to a cell not yet read in the current fetch is visible in the committed row.
- Simultaneous request edge and write: the request is accepted, and the first read stalls one cycle.
- Reset mid-fetch: everything returns to reset values on the next edge, and no commit occurs.
- Row and rowReady are registered outputs only; they have no combinational path from inputs.

Optional Feature:
- BOARD_CLEAR_EN
- When defined:
  - Adds input clear_req (1 bit) and output clear_busy (1 bit).
  - A clear_req pulse while not clearing sets clear_busy = 1 and sweeps addresses 0..199, writing 0 to one cell per cycle.
  - clear_busy drops on the edge after address 199 is written.
  - While clearing, wr_en is ignored and the fetch FSM stalls in its current state; the request edge is still latched.
  - clear_req during a clear is ignored. Reset also aborts a clear.
- When not defined: the ports are absent and the store is cleared only by reset.

Test Plan:
- Reset, then write cell (col 3, row 5) = 16'h0F00, then raise LD_Row with rowNum = 5 -> rowReady = 1 exactly 12 edges later, Row[3] = 16'h0F00, all other columns 0.
- Hold LD_Row high for 40 cycles with rowNum = 5 -> exactly one fetch, rowReady stays 1 after the commit, and no further drop.
- Start a fetch of row 2; 4 cycles later issue an in-range write -> commit at 13 edges, and the write to a not-yet-read column of row 2 appears in Row.
- Request rowNum = 25 -> Row all zeros after 12 edges and rowReady = 1.
- Request row 1, then pulse LD_Row for row 7 at edge 6 -> no commit for row 1; Row holds row 7 data 12 edges after the second accept.
- With BOARD_CLEAR_EN: fill row 0 with 16'h0FFF, pulse clear_req, then request row 0 -> clear_busy high for 200 cycles; the fetch completes after the clear, and Row is all zeros.
